// File: rtl/intc_pkg.sv
//-----------------------------------------------------------------------------
// intc_pkg : shared state encoding, vector defaults and ID-width helper
//            for the intc_sched interrupt scheduler.
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_t;

  localparam int unsigned DEF_VEC_BASE   = 32'h0000_03C0;
  localparam int unsigned DEF_VEC_STRIDE = 8;

  // A single source still needs one bit to carry its index.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/intc_prio_enc.sv
//-----------------------------------------------------------------------------
// intc_prio_enc : combinational lowest-index-wins priority encoder.
// Revision      : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]             i_req,
  output logic [id_width(N)-1:0]   o_idx,
  output logic                     o_valid
);

  localparam int ID_W = id_width(N);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/intc_sched.sv
//-----------------------------------------------------------------------------
// intc_sched : edge-latched, maskable, non-nesting interrupt scheduler with
//              req/ack handshake to the core control path.
//              Optional macro INTC_SYNC_EN adds a 2-flop irq synchronizer.
// Revision   : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module intc_sched
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter int          VEC_W      = 10,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_IRQ-1:0]            irq,
  input  logic                          gie,
  input  logic                          mask_we,
  input  logic [NUM_IRQ-1:0]            mask_in,
  output logic [NUM_IRQ-1:0]            mask_out,
  output logic [NUM_IRQ-1:0]            pending,
  output logic                          int_req,
  output logic [VEC_W-1:0]              int_vector,
  output logic [id_width(NUM_IRQ)-1:0]  int_id,
  input  logic                          int_ack,
  input  logic                          int_done,
  output logic                          busy
);

  localparam int ID_W = id_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] w_irq;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ID_W-1:0]    w_win;
  logic               w_win_vld;

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;

  state_t             r_state, w_state_nx;
  logic               r_req,   w_req_nx;
  logic [VEC_W-1:0]   r_vec,   w_vec_nx;
  logic [ID_W-1:0]    r_id,    w_id_nx;
  logic               r_busy,  w_busy_nx;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = irq;
`endif

  assign w_edge = w_irq & ~r_irq_prev;
  assign w_cand = r_pending & r_mask;

  intc_prio_enc #(
    .N       (NUM_IRQ)
  ) u_prio_enc (
    .i_req   (w_cand),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  // Set after clear so a fresh edge in the ack cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
    end else begin
      r_irq_prev <= w_irq;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_vec   <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_req   <= w_req_nx;
      r_vec   <= w_vec_nx;
      r_id    <= w_id_nx;
      r_busy  <= w_busy_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_vec_nx   = r_vec;
    w_id_nx    = r_id;
    w_busy_nx  = r_busy;
    w_clr      = '0;
    case (r_state)
      IDLE: begin
        if (gie && w_win_vld) begin
          w_id_nx    = w_win;
          w_vec_nx   = VEC_W'(VEC_BASE) + VEC_W'(w_win) * VEC_W'(VEC_STRIDE);
          w_req_nx   = 1'b1;
          w_state_nx = REQUEST;
        end
      end
      REQUEST: begin
        if (int_ack) begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = (r_id == ID_W'(i));
          end
          w_req_nx   = 1'b0;
          w_busy_nx  = 1'b1;
          w_state_nx = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          w_busy_nx  = 1'b0;
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_req_nx   = 1'b0;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
    endcase
  end

  assign mask_out   = r_mask;
  assign pending    = r_pending;
  assign int_req    = r_req;
  assign int_vector = r_vec;
  assign int_id     = r_id;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_intc_sched.sv
//-----------------------------------------------------------------------------
// tb_intc_sched : directed self-checking bench for intc_sched (default build).
// Revision      : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_intc_sched;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       gie;
  logic       mask_we;
  logic [3:0] mask_in;
  logic [3:0] mask_out;
  logic [3:0] pending;
  logic       int_req;
  logic [9:0] int_vector;
  logic [1:0] int_id;
  logic       int_ack;
  logic       int_done;
  logic       busy;

  int checks;
  int failures;

  intc_sched #(
    .NUM_IRQ    (4),
    .VEC_W      (10),
    .VEC_BASE   (32'h3C0),
    .VEC_STRIDE (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .gie        (gie),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .mask_out   (mask_out),
    .pending    (pending),
    .int_req    (int_req),
    .int_vector (int_vector),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    irq      = 4'b0000;
    gie      = 1'b0;
    mask_we  = 1'b0;
    mask_in  = 4'b0000;
    int_ack  = 1'b0;
    int_done = 1'b0;
    step(3);

    chk("rst_req",     {31'b0, int_req}, 32'd0);
    chk("rst_pending", {28'b0, pending}, 32'd0);
    chk("rst_mask",    {28'b0, mask_out}, 32'd0);
    chk("rst_busy",    {31'b0, busy}, 32'd0);
    chk("rst_vector",  {22'b0, int_vector}, 32'd0);
    chk("rst_id",      {30'b0, int_id}, 32'd0);

    // Basic single source 2
    reset = 1'b0;
    mask_we = 1'b1; mask_in = 4'b1111;
    step(1);
    mask_we = 1'b0; gie = 1'b1;
    chk("t1_mask", {28'b0, mask_out}, 32'hF);
    irq = 4'b0100;
    step(1);
    chk("t1_pend",  {28'b0, pending}, 32'h4);
    chk("t1_req_n1", {31'b0, int_req}, 32'd0);
    step(1);
    chk("t1_req",  {31'b0, int_req}, 32'd1);
    chk("t1_id",   {30'b0, int_id}, 32'd2);
    chk("t1_vec",  {22'b0, int_vector}, 32'h3D0);
    step(1);
    chk("t1_req_hold", {31'b0, int_req}, 32'd1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("t1_ack_pend", {28'b0, pending}, 32'h0);
    chk("t1_ack_busy", {31'b0, busy}, 32'd1);
    chk("t1_ack_req",  {31'b0, int_req}, 32'd0);
    step(3);
    chk("t1_svc_busy", {31'b0, busy}, 32'd1);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("t1_done_busy", {31'b0, busy}, 32'd0);
    chk("t1_done_req",  {31'b0, int_req}, 32'd0);
    irq = 4'b0000;
    step(2);

    // Simultaneous sources 3 and 1
    irq = 4'b1010;
    step(2);
    chk("t2_req1", {31'b0, int_req}, 32'd1);
    chk("t2_id1",  {30'b0, int_id}, 32'd1);
    chk("t2_vec1", {22'b0, int_vector}, 32'h3C8);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("t2_pend", {28'b0, pending}, 32'h8);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("t2_idle_req", {31'b0, int_req}, 32'd0);
    step(1);
    chk("t2_req3", {31'b0, int_req}, 32'd1);
    chk("t2_id3",  {30'b0, int_id}, 32'd3);
    chk("t2_vec3", {22'b0, int_vector}, 32'h3D8);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0; int_done = 1'b1;
    step(1);
    int_done = 1'b0; irq = 4'b0000;
    step(2);

    // Masked pending source 0
    mask_we = 1'b1; mask_in = 4'b0000;
    step(1);
    mask_we = 1'b0;
    irq = 4'b0001;
    step(2);
    chk("t3_pend",   {28'b0, pending}, 32'h1);
    chk("t3_no_req", {31'b0, int_req}, 32'd0);
    mask_we = 1'b1; mask_in = 4'b0001;
    step(1);
    mask_we = 1'b0;
    chk("t3_req_n1", {31'b0, int_req}, 32'd0);
    step(1);
    chk("t3_req", {31'b0, int_req}, 32'd1);
    chk("t3_id",  {30'b0, int_id}, 32'd0);
    chk("t3_vec", {22'b0, int_vector}, 32'h3C0);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0; int_done = 1'b1;
    step(1);
    int_done = 1'b0; irq = 4'b0000;
    mask_we = 1'b1; mask_in = 4'b1111;
    step(1);
    mask_we = 1'b0;
    step(1);

    // New edge while servicing source 1
    irq = 4'b0010;
    step(2);
    chk("t4_id1", {30'b0, int_id}, 32'd1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    irq = 4'b0011;
    step(1);
    chk("t4_pend",   {28'b0, pending}, 32'h1);
    chk("t4_no_req", {31'b0, int_req}, 32'd0);
    chk("t4_busy",   {31'b0, busy}, 32'd1);
    step(1);
    chk("t4_no_req2", {31'b0, int_req}, 32'd0);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    chk("t4_idle_req", {31'b0, int_req}, 32'd0);
    step(1);
    chk("t4_req0", {31'b0, int_req}, 32'd1);
    chk("t4_id0",  {30'b0, int_id}, 32'd0);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0; int_done = 1'b1;
    step(1);
    int_done = 1'b0; irq = 4'b0000;
    step(2);

    // Re-edge of the active source in the ack cycle
    irq = 4'b0100;
    step(2);
    chk("t5_id2", {30'b0, int_id}, 32'd2);
    irq = 4'b0000;
    step(1);
    irq = 4'b0100; int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("t5_set_wins", {28'b0, pending}, 32'h4);
    chk("t5_busy",     {31'b0, busy}, 32'd1);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    step(1);
    chk("t5_req2",  {31'b0, int_req}, 32'd1);
    chk("t5_id2b",  {30'b0, int_id}, 32'd2);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0; int_done = 1'b1;
    step(1);
    int_done = 1'b0; irq = 4'b0000;
    step(2);

    // Reset in REQUEST, ack held afterwards
    irq = 4'b0001;
    step(2);
    chk("t6_req", {31'b0, int_req}, 32'd1);
    reset = 1'b1; int_ack = 1'b1;
    step(1);
    chk("t6_rst_req",  {31'b0, int_req}, 32'd0);
    chk("t6_rst_pend", {28'b0, pending}, 32'h0);
    chk("t6_rst_mask", {28'b0, mask_out}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step(3);
    chk("t6_ack_busy", {31'b0, busy}, 32'd0);
    chk("t6_ack_req",  {31'b0, int_req}, 32'd0);
    int_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intc_sched.md
Name: intc_sched

Overview:
- Interrupt scheduler for the single-cycle processor.
- Latches rising-edge requests from NUM_IRQ peripheral lines and applies a writable mask.
- Picks the lowest-index pending, unmasked source and presents a vector address to the control path via a req/ack handshake.
- Blocks further interrupts until the core signals return from the service routine; no nesting.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..8)
- VEC_W, 10, width of program-counter vector address
- VEC_BASE, 10'h3C0, vector address of source 0
- VEC_STRIDE, 8, address spacing between consecutive source vectors

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- irq  in  NUM_IRQ  peripheral request lines, edge-triggered on rising edge
- gie  in  1  global interrupt enable from core
- mask_we  in  1  write strobe for mask register
- mask_in  in  NUM_IRQ  new mask value (1 = enabled)
- mask_out  out  NUM_IRQ  current mask register
- pending  out  NUM_IRQ  current pending register
- int_req  out  1  interrupt request to control unit
- int_vector  out  VEC_W  target address of the requested handler
- int_id  out  clog2(NUM_IRQ) or 1 bit minimum  index of request/active source
- int_ack  in  1  core accepted request this cycle (PC pushed to return stack)
- int_done  in  1  core executed return-from-interrupt this cycle
- busy  out  1  handler in service (state SERVICE)

Behaviour:
- Reset (synchronous, active-high, clk edge), applied in any state including mid-handshake:
  - state=IDLE; irq_prev=0; pending=0; mask=0 (all disabled)
  - int_req=0, int_vector=0, int_id=0, busy=0
- Edge detect: edge = irq & ~irq_prev; irq_prev <= irq every cycle. A line held high produces exactly one edge.
- Pending register:
  - Set: pending[i] <= 1 on edge[i], in every state.
  - Clear: pending[i] clears only on int_ack in REQUEST, for i == int_id.
  - Set and clear of the same bit in the same cycle: set wins.
- Mask: on mask_we, mask <= mask_in the next edge, in every state. Masking never clears pending.
- Candidate selection: cand = pending & mask. Winner is the lowest index with cand bit set.
- IDLE:
  - Condition: gie=1 and cand != 0.
  - Action: int_id <= winner; int_vector <= VEC_BASE + winner*VEC_STRIDE (mod 2^VEC_W); int_req <= 1; go to REQUEST.
  - Latency: irq edge at cycle N gives int_req=1 visible in cycle N+2 (edge registered into pending at N+1, request registered at N+2).
- REQUEST:
  - int_req held high; int_vector and int_id frozen. No retraction, even if the mask bit or gie drops.
  - int_ack=1: clear pending[int_id]; int_req <= 0; busy <= 1; go to SERVICE.
- SERVICE:
  - int_id keeps the active source; no new request is issued.
  - int_done=1: busy <= 0; go to IDLE. A new request may then rise on the following cycle.
- Ignored inputs: int_ack outside REQUEST; int_done outside SERVICE.
- int_ack and int_done together in REQUEST: the ack is honoured and the done is ignored.

Optional Feature:
- Macro: INTC_SYNC_EN.
- Defined: irq passes through a 2-flop synchronizer (reset 0) ahead of edge detect, so irq-to-int_req latency becomes 4 cycles.
- Undefined: irq is sampled directly and latency is 2 cycles. Use only when sources are synchronous to clk.

Decomposition:
- Package intc_pkg holds:
  - state encoding constants: IDLE=2'b00, REQUEST=2'b01, SERVICE=2'b10 (2'b11 recovers to IDLE)
  - default VEC_BASE and VEC_STRIDE
  - ID width function
- Sub-module intc_prio_enc: combinational lowest-index priority encoder over NUM_IRQ bits, outputs index plus valid.

Test Plan:
- Reset then mask=4'b1111, gie=1, irq[2] rising at cycle 10 -> int_req=1 at cycle 12, int_id=2, int_vector=10'h3D0; ack at 14 -> pending[2]=0, busy=1; done at 20 -> busy=0, IDLE.
- irq[3] and irq[1] rise in the same cycle, mask=4'b1111 -> first request int_id=1 (vector 10'h3C8); after ack+done, second request int_id=3 (vector 10'h3D8).
- mask=4'b0000, irq[0] rises -> pending=4'b0001, int_req stays 0; write mask=4'b0001 -> int_req=1 two cycles after the write, int_id=0.
- During SERVICE of source 1, irq[0] rises -> pending[0]=1 and no int_req until int_done; int_req rises the cycle after IDLE is re-entered.
- In REQUEST for source 2, irq[2] re-edges in the ack cycle -> pending[2] stays 1 (set wins), and a second request follows after done.
- Assert reset in REQUEST with int_req=1 -> next cycle int_req=0, pending=0, mask=0, state IDLE; int_ack held high thereafter -> no effect.
